stim_sweep_ctrl: RTL and testbench

Programmable tone-sequence scheduler for the PWC sine stimulus source. It holds a small table of (frequency, amplitude, dwell) entries and steps through them on command, converting codes to real-valued `freq`/`amplitude` that configure a sine generator. It also flags settled intervals (`tone_valid`) so checkers sample only after each retune. It sits between the testbench sequencer and the sine source in mLingua stimulus setups.

---
 rtl/stim_sweep_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_stim_sweep_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stim_sweep_ctrl.sv
// Tone-sequence scheduler: steps a small (freq, amp, dwell) table and
// blanks tone_valid for a fixed settle interval after each retune.
module stim_sweep_ctrl #(
   parameter int  DEPTH    = 8,
   parameter int  AW       = 3,
   parameter int  FW       = 16,
   parameter int  AMPW     = 12,
   parameter int  DWW      = 16,
   parameter int  SETTLE   = 4,
   parameter real FREQ_LSB = 1.0e6,
   parameter real AMP_LSB  = 1.0e-3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_we,
   input  logic [AW-1:0]   cfg_addr,
   input  logic [FW-1:0]   cfg_freq,
   input  logic [AMPW-1:0] cfg_amp,
   input  logic [DWW-1:0]  cfg_dwell,
   input  logic [AW:0]     num_steps,
   input  logic            loop,
   input  logic            start,
   input  logic            abort,
   output logic            busy,
   output logic [AW-1:0]   step_idx,
   output logic [FW-1:0]   freq_code,
   output logic [AMPW-1:0] amp_code,
   output real             freq,
   output real             amplitude,
   output logic            tone_valid,
   output logic            step_done,
   output logic            seq_done,
   output logic            cfg_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_DWELL
   } state_t;

   localparam logic [DWW-1:0] SET_M1 =
      (SETTLE > 0) ? DWW'(SETTLE - 1) : '0;
   localparam logic [AW:0] DEP = (AW+1)'(DEPTH);

   logic [FW-1:0]   tbl_freq  [DEPTH];
   logic [AMPW-1:0] tbl_amp   [DEPTH];
   logic [DWW-1:0]  tbl_dwell [DEPTH];

   state_t          state, nstate;
   logic [AW-1:0]   idx, nidx, lidx;
   logic [FW-1:0]   fcode, nfcode;
   logic [AMPW-1:0] acode, nacode;
   logic [DWW-1:0]  cnt, ncnt;
   logic [AW:0]     n_lat, nn_lat, clamp;
   logic            loop_lat, nloop;
   logic            tv, ntv, sd, nsd, qd, nqd, err, nerr;
   logic            load;

   function automatic logic [DWW-1:0] dwell_m1(input logic [DWW-1:0] d);
      return (d == '0) ? '0 : d - 1'b1;
   endfunction

   // Table only accepts writes while idle; contents survive rst.
   always_ff @(posedge clk) begin
      if (cfg_we && state == S_IDLE) begin
         tbl_freq[cfg_addr]  <= cfg_freq;
         tbl_amp[cfg_addr]   <= cfg_amp;
         tbl_dwell[cfg_addr] <= cfg_dwell;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         idx      <= '0;
         fcode    <= '0;
         acode    <= '0;
         cnt      <= '0;
         n_lat    <= '0;
         loop_lat <= 1'b0;
         tv       <= 1'b0;
         sd       <= 1'b0;
         qd       <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= nstate;
         idx      <= nidx;
         fcode    <= nfcode;
         acode    <= nacode;
         cnt      <= ncnt;
         n_lat    <= nn_lat;
         loop_lat <= nloop;
         tv       <= ntv;
         sd       <= nsd;
         qd       <= nqd;
         err      <= nerr;
      end
   end

   always_comb begin
      nstate = state;
      nidx   = idx;
      nfcode = fcode;
      nacode = acode;
      ncnt   = cnt;
      nn_lat = n_lat;
      nloop  = loop_lat;
      nerr   = 1'b0;
      nqd    = 1'b0;
      load   = 1'b0;
      lidx   = '0;
      clamp  = (num_steps > DEP) ? DEP : num_steps;
      unique case (state)
         S_IDLE: begin
            if (start && !abort) begin
               if (clamp == '0) begin
                  nerr = 1'b1;
               end else begin
                  nn_lat = clamp;
                  nloop  = loop;
                  load   = 1'b1;
               end
            end
         end
         S_SETTLE: begin
            if (cnt == '0) begin
               nstate = S_DWELL;
               ncnt   = dwell_m1(tbl_dwell[idx]);
            end else begin
               ncnt = cnt - 1'b1;
            end
         end
         S_DWELL: begin
            if (cnt != '0) begin
               ncnt = cnt - 1'b1;
            end else if ({1'b0, idx} + 1'b1 < n_lat) begin
               load = 1'b1;
               lidx = idx + 1'b1;
            end else if (loop_lat) begin
               load = 1'b1;
            end else begin
               nstate = S_IDLE;
               nqd    = 1'b1;
               nidx   = '0;
               nfcode = '0;
               nacode = '0;
               ncnt   = '0;
            end
         end
         default: nstate = S_IDLE;
      endcase
      if (load) begin
         nidx   = lidx;
         nfcode = tbl_freq[lidx];
         nacode = tbl_amp[lidx];
         if (SETTLE > 0) begin
            nstate = S_SETTLE;
            ncnt   = SET_M1;
         end else begin
            nstate = S_DWELL;
            ncnt   = dwell_m1(tbl_dwell[lidx]);
         end
      end
      if (cfg_we && state != S_IDLE)
         nerr = 1'b1;
      if (abort) begin
         nstate = S_IDLE;
         nidx   = '0;
         nfcode = '0;
         nacode = '0;
         ncnt   = '0;
         nqd    = 1'b0;
      end
      ntv = (nstate == S_DWELL);
      nsd = (nstate == S_DWELL) && (ncnt == '0);
   end

   assign busy       = (state != S_IDLE);
   assign step_idx   = idx;
   assign freq_code  = fcode;
   assign amp_code   = acode;
   assign tone_valid = tv;
   assign step_done  = sd;
   assign seq_done   = qd;
   assign cfg_err    = err;
   assign freq       = real'(fcode) * FREQ_LSB;
   assign amplitude  = real'(acode) * AMP_LSB;

endmodule

// File: tb/tb_stim_sweep_ctrl.sv
// Directed bench for stim_sweep_ctrl: cycle-indexed capture of a run,
// then hand-derived expectations at specific cycles.
module tb_stim_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [15:0] cfg_freq;
   logic [11:0] cfg_amp;
   logic [15:0] cfg_dwell;
   logic [3:0]  num_steps;
   logic        loop;
   logic        start;
   logic        abort;
   logic        busy;
   logic [2:0]  step_idx;
   logic [15:0] freq_code;
   logic [11:0] amp_code;
   real         freq_r;
   real         amp_r;
   logic        tone_valid;
   logic        step_done;
   logic        seq_done;
   logic        cfg_err;

   int checks = 0;
   int errors = 0;
   int abort_at = 0;
   int we_at = 0;

   logic        r_busy [64];
   logic        r_tv   [64];
   logic        r_sd   [64];
   logic        r_qd   [64];
   logic        r_err  [64];
   logic [2:0]  r_idx  [64];
   logic [15:0] r_fc   [64];
   longint      r_fhz  [64];
   longint      r_amv  [64];

   stim_sweep_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_freq   (cfg_freq),
      .cfg_amp    (cfg_amp),
      .cfg_dwell  (cfg_dwell),
      .num_steps  (num_steps),
      .loop       (loop),
      .start      (start),
      .abort      (abort),
      .busy       (busy),
      .step_idx   (step_idx),
      .freq_code  (freq_code),
      .amp_code   (amp_code),
      .freq       (freq_r),
      .amplitude  (amp_r),
      .tone_valid (tone_valid),
      .step_done  (step_done),
      .seq_done   (seq_done),
      .cfg_err    (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs,
                        input longint exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input int f, input int am, input int d);
      cfg_we    = 1'b1;
      cfg_addr  = 3'(a);
      cfg_freq  = 16'(f);
      cfg_amp   = 12'(am);
      cfg_dwell = 16'(d);
      tick();
      cfg_we = 1'b0;
   endtask

   // Cycle c holds the outputs seen after the c-th edge counting the
   // edge that samples start as edge 1.
   task automatic run(input int n, input int ns, input bit lp);
      num_steps = 4'(ns);
      loop      = lp;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= n; c++) begin
         r_busy[c] = busy;
         r_tv[c]   = tone_valid;
         r_sd[c]   = step_done;
         r_qd[c]   = seq_done;
         r_err[c]  = cfg_err;
         r_idx[c]  = step_idx;
         r_fc[c]   = freq_code;
         r_fhz[c]  = longint'($rtoi(freq_r));
         r_amv[c]  = longint'($rtoi(amp_r * 1000.0 + 0.5));
         abort = (c == abort_at);
         if (c == we_at) begin
            cfg_we   = 1'b1;
            cfg_addr = 3'd0;
            cfg_freq = 16'd999;
         end else begin
            cfg_we = 1'b0;
         end
         tick();
      end
      abort    = 1'b0;
      cfg_we   = 1'b0;
      abort_at = 0;
      we_at    = 0;
   endtask

   function automatic int count(input int lo, input int hi, input int sel);
      int k = 0;
      for (int c = lo; c <= hi; c++) begin
         case (sel)
            0: k += int'(r_tv[c]);
            1: k += int'(r_sd[c]);
            2: k += int'(r_qd[c]);
            default: k += int'(r_busy[c]);
         endcase
      end
      return k;
   endfunction

   function automatic int first_tv(input int lo, input int hi);
      for (int c = lo; c <= hi; c++)
         if (r_tv[c]) return c;
      return -1;
   endfunction

   initial begin
      rst = 1'b1;
      cfg_we = 1'b0; cfg_addr = '0; cfg_freq = '0; cfg_amp = '0;
      cfg_dwell = '0; num_steps = '0; loop = 1'b0;
      start = 1'b0; abort = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("rst_busy", busy, 0);
      check("rst_idx", step_idx, 0);
      check("rst_fc", freq_code, 0);
      check("rst_ac", amp_code, 0);
      check("rst_tv", tone_valid, 0);
      check("rst_flags", {step_done, seq_done, cfg_err}, 0);
      check("rst_freq", longint'($rtoi(freq_r)), 0);

      // single entry, SETTLE = 4
      wr(0, 100, 500, 10);
      run(20, 1, 0);
      check("t1_busy1", r_busy[1], 1);
      check("t1_freq", r_fhz[1], 100000000);
      check("t1_amp", r_amv[1], 500);
      check("t1_tv_cnt", count(1, 20, 0), 10);
      check("t1_tv_first", first_tv(1, 20), 5);
      check("t1_sd14", r_sd[14], 1);
      check("t1_sd_cnt", count(1, 20, 1), 1);
      check("t1_qd15", r_qd[15], 1);
      check("t1_qd_cnt", count(1, 20, 2), 1);
      check("t1_busy_cnt", count(1, 20, 3), 14);
      check("t1_fc_end", r_fc[15], 0);

      // looping 3 entries, dwells 3/0/5, aborted after two passes
      wr(0, 10, 1, 3);
      wr(1, 20, 2, 0);
      wr(2, 30, 3, 5);
      abort_at = 42;
      run(44, 3, 1);
      check("t2_idx1", r_idx[1], 0);
      check("t2_idx8", r_idx[8], 1);
      check("t2_fc8", r_fc[8], 20);
      check("t2_idx13", r_idx[13], 2);
      check("t2_idx22", r_idx[22], 0);
      check("t2_sd7", r_sd[7], 1);
      check("t2_sd12", r_sd[12], 1);
      check("t2_sd21", r_sd[21], 1);
      check("t2_sd_cnt", count(1, 44, 1), 6);
      check("t2_e1_tv", {r_tv[11], r_tv[12], r_tv[13]}, 3'b010);
      check("t2_qd_cnt", count(1, 44, 2), 0);
      check("t2_abort", r_busy[43], 0);

      // abort on 2nd dwell cycle of entry 1, cfg write while busy
      wr(1, 20, 2, 4);
      abort_at = 13;
      we_at = 3;
      run(20, 3, 0);
      check("t3_tv13", r_tv[13], 1);
      check("t3_idx13", r_idx[13], 1);
      check("t3_busy14", r_busy[14], 0);
      check("t3_fc14", r_fc[14], 0);
      check("t3_sd_late", count(13, 20, 1), 0);
      check("t3_qd_cnt", count(1, 20, 2), 0);
      check("t3_err", {r_err[3], r_err[4], r_err[5]}, 3'b010);

      run(8, 1, 0);
      check("t4_tbl_kept", r_fc[1], 10);

      // num_steps = 0 is rejected
      num_steps = 4'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t5_err", cfg_err, 1);
      check("t5_busy", busy, 0);
      tick();
      check("t5_err_pulse", cfg_err, 0);

      // start with abort in IDLE
      num_steps = 4'd1;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("t6_busy", busy, 0);
      check("t6_err", cfg_err, 0);

      // num_steps = 12 clamps to 8
      for (int i = 0; i < 8; i++) wr(i, i + 1, i, 1);
      run(45, 12, 0);
      check("t7_idx36", r_idx[36], 7);
      check("t7_fc36", r_fc[36], 8);
      check("t7_sd_cnt", count(1, 45, 1), 8);
      check("t7_busy40", r_busy[40], 1);
      check("t7_busy41", r_busy[41], 0);
      check("t7_qd41", r_qd[41], 1);

      // asynchronous reset mid-clock
      num_steps = 4'd12;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      check("t8_busy", busy, 0);
      check("t8_fc", freq_code, 0);
      check("t8_freq", longint'($rtoi(freq_r)), 0);
      check("t8_idx", step_idx, 0);
      tick();
      rst = 1'b0;
      tick();
      run(4, 1, 0);
      check("t8_tbl_kept", r_fc[1], 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
